// File: rtl/uc_arbiter.sv
// rtl/uc_arbiter.sv - round-robin unit-clause arbiter; UCA_CONFLICT_EN enables assignment table, duplicate filter and conflict halt
module uc_arbiter #(
    parameter int  DATA_LEN = 512,
    parameter int  NUM_ENG  = 4,
    localparam int W        = $clog2(DATA_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ENG-1:0]  eng_valid,
    input  logic signed [W-1:0] eng_lit [NUM_ENG],
    output logic [NUM_ENG-1:0]  eng_ready,
    input  logic                ucq_full,
    output logic                ucq_push,
    output logic signed [W-1:0] ucq_data,
    input  logic                clear,
    output logic                conflict,
    output logic [W:0]          uc_cnt
);

    localparam int PW  = $clog2(NUM_ENG);
    localparam int TBL = 2 ** (W - 1);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t              state_q;
    logic [PW-1:0]       ptr_q;
    logic [PW-1:0]       ptr_d;
    logic                conflict_q;
    logic [W:0]          cnt_q;
    logic [W:0]          cnt_d;

    logic                grant_en;
    logic                acc;
    logic [PW-1:0]       gnt_idx;
    logic [NUM_ENG-1:0]  gnt_oh;
    logic signed [W-1:0] acc_lit;
    logic                lit_nz;
    logic                push;
    logic                cfl;

    // Grants are only offered while running, the queue has room, and no clear/reset is in progress
    assign grant_en = !rst && (state_q == RUN) && !ucq_full && !clear;

    // Round-robin search starting at ptr_q; the first valid engine wins
    always_comb begin
        int            j;
        logic [PW-1:0] j_idx;
        acc     = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        j       = 0;
        j_idx   = '0;
        if (grant_en) begin
            for (int k = 0; k < NUM_ENG; k++) begin
                j = int'(ptr_q) + k;
                if (j >= NUM_ENG) begin
                    j = j - NUM_ENG;
                end
                j_idx = PW'(j);
                if (!acc && eng_valid[j_idx]) begin
                    acc           = 1'b1;
                    gnt_idx       = j_idx;
                    gnt_oh[j_idx] = 1'b1;
                end
            end
        end
    end

    assign eng_ready = gnt_oh;
    assign acc_lit   = eng_lit[gnt_idx];
    assign lit_nz    = (acc_lit != '0);

`ifdef UCA_CONFLICT_EN
    logic [TBL-1:0]      assigned_q;
    logic [TBL-1:0]      pol_q;
    logic                acc_neg;
    logic [W-1:0]        acc_mag;
    logic [W-2:0]        acc_idx;

    // Magnitude is truncated to W-1 bits, so the most negative literal lands on index 0
    assign acc_neg = acc_lit[W-1];
    assign acc_mag = acc_neg ? W'(-acc_lit) : W'(acc_lit);
    assign acc_idx = acc_mag[W-2:0];

    // Classify the accepted literal against the pre-edge table contents
    always_comb begin
        push = 1'b0;
        cfl  = 1'b0;
        if (acc && lit_nz) begin
            if (!assigned_q[acc_idx]) begin
                push = 1'b1;
            end else if (pol_q[acc_idx] != acc_neg) begin
                cfl = 1'b1;
            end
        end
    end

    // Assignment table: wiped on reset/clear, records polarity of every pushed literal
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            assigned_q <= '0;
            pol_q      <= '0;
        end else if (push) begin
            assigned_q[acc_idx] <= 1'b1;
            pol_q[acc_idx]      <= acc_neg;
        end
    end
`else
    // Without the table every accepted non-zero literal goes straight to the queue
    always_comb begin
        push = acc && lit_nz;
        cfl  = 1'b0;
    end
`endif

    // Next pointer follows the granted engine; saturating push counter
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (acc) begin
            if (int'(gnt_idx) == NUM_ENG - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + PW'(1);
            end
        end
        if (push && (cnt_q != '1)) begin
            cnt_d = cnt_q + (W + 1)'(1);
        end
    end

    // RUN/HALT control with pointer, sticky conflict and counter; clear beats any accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            ptr_q      <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else if (clear) begin
            state_q    <= RUN;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            case (state_q)
                RUN: begin
                    if (cfl) begin
                        state_q    <= HALT;
                        conflict_q <= 1'b1;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign ucq_push = push;
    assign ucq_data = push ? acc_lit : '0;
    assign conflict = conflict_q;
    assign uc_cnt   = cnt_q;

endmodule

// File: tb/tb_uc_arbiter.sv
// tb/tb_uc_arbiter.sv - scoreboard bench for uc_arbiter (table behaviour checked when UCA_CONFLICT_EN is defined)
module tb_uc_arbiter;

    localparam int W    = 9;
    localparam int NE   = 4;
    localparam int TBL  = 256;
    localparam int CMAX = 1023;

    logic                clk = 1'b0;
    logic                rst;
    logic [NE-1:0]       eng_valid;
    logic signed [W-1:0] eng_lit [NE];
    logic [NE-1:0]       eng_ready;
    logic                ucq_full;
    logic                ucq_push;
    logic signed [W-1:0] ucq_data;
    logic                clear;
    logic                conflict;
    logic [W:0]          uc_cnt;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    int m_ptr;
    bit m_halt;
    bit m_conflict;
    int m_cnt;
    bit m_asg [TBL];
    bit m_pol [TBL];

    always #5 clk = ~clk;

    uc_arbiter #(.DATA_LEN(512), .NUM_ENG(NE)) dut (
        .clk       (clk),
        .rst       (rst),
        .eng_valid (eng_valid),
        .eng_lit   (eng_lit),
        .eng_ready (eng_ready),
        .ucq_full  (ucq_full),
        .ucq_push  (ucq_push),
        .ucq_data  (ucq_data),
        .clear     (clear),
        .conflict  (conflict),
        .uc_cnt    (uc_cnt)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_wipe();
        for (int i = 0; i < TBL; i++) begin
            m_asg[i] = 1'b0;
            m_pol[i] = 1'b0;
        end
    endtask

    // One clock: drive at posedge+1, check at negedge, advance the model, return at posedge+1
    task automatic cycle(input logic [NE-1:0] v, input int l0, input int l1, input int l2,
                         input int l3, input bit full, input bit clr, input bit rs);
        int lits [NE];
        int g;
        int j;
        int lit;
        int ix;
        bit push_e;
        bit cfl_e;
        lits = '{l0, l1, l2, l3};
        rst       = rs;
        clear     = clr;
        ucq_full  = full;
        eng_valid = v;
        for (int i = 0; i < NE; i++) eng_lit[i] = W'(lits[i]);
        g = -1;
        if (!rs && !m_halt && !full && !clr) begin
            for (int k = 0; k < NE; k++) begin
                j = (m_ptr + k) % NE;
                if (g < 0 && v[j]) g = j;
            end
        end
        push_e = 1'b0;
        cfl_e  = 1'b0;
        lit    = 0;
        ix     = 0;
        if (g >= 0) begin
            lit = lits[g];
            ix  = ((lit < 0) ? -lit : lit) % TBL;
            if (lit != 0) begin
`ifdef UCA_CONFLICT_EN
                if (!m_asg[ix]) push_e = 1'b1;
                else if (m_pol[ix] != (lit < 0)) cfl_e = 1'b1;
`else
                push_e = 1'b1;
`endif
            end
        end
        if (push_e) exp_q.push_back(lit);
        @(negedge clk);
        check("eng_ready", int'(eng_ready), (g >= 0) ? (1 << g) : 0);
        check("ucq_push", int'(ucq_push), int'(push_e));
        if (ucq_push) begin
            if (exp_q.size() > 0) check("ucq_data", int'(ucq_data), exp_q.pop_front());
            else check("spurious_push", int'(ucq_push), 0);
        end else begin
            check("ucq_data_idle", int'(ucq_data), 0);
            if (push_e) void'(exp_q.pop_back());
        end
        check("conflict", int'(conflict), int'(m_conflict));
        check("uc_cnt", int'(uc_cnt), m_cnt);
        if (rs) begin
            m_ptr = 0; m_halt = 0; m_conflict = 0; m_cnt = 0;
            model_wipe();
        end else if (clr) begin
            m_halt = 0; m_conflict = 0; m_cnt = 0;
            model_wipe();
        end else if (g >= 0) begin
            m_ptr = (g + 1) % NE;
            if (push_e) begin
                if (m_cnt < CMAX) m_cnt++;
                m_asg[ix] = 1'b1;
                m_pol[ix] = (lit < 0);
            end
            if (cfl_e) begin
                m_conflict = 1'b1;
                m_halt     = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle('0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        ucq_full  = 1'b0;
        eng_valid = '0;
        for (int i = 0; i < NE; i++) eng_lit[i] = '0;
        m_ptr = 0; m_halt = 0; m_conflict = 0; m_cnt = 0;
        model_wipe();
        repeat (2) @(posedge clk);
        #1;

        // reset state with every engine requesting
        cycle(4'hF, 1, 2, 3, 4, 1'b0, 1'b0, 1'b1);
        check("rst_cnt", int'(uc_cnt), 0);
        check("rst_conflict", int'(conflict), 0);

        // round robin across all four engines
        repeat (4) cycle(4'hF, 5, -6, 7, 8, 1'b0, 1'b0, 1'b0);
        idle();
        check("rr_cnt", int'(uc_cnt), 4);

        // literal 0 consumed without push, pointer still advances
        cycle(4'b0010, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle(4'b0101, 11, 0, 12, 0, 1'b0, 1'b0, 1'b0);
        check("zero_cnt", int'(uc_cnt), 5);

        // full stalls everything, release grants engine at ptr
        repeat (3) cycle(4'hF, 21, 22, 23, 24, 1'b1, 1'b0, 1'b0);
        cycle(4'hF, 21, 22, 23, 24, 1'b0, 1'b0, 1'b0);

        // clear blocks grants and zeroes the counter
        cycle(4'hF, 31, 32, 33, 34, 1'b0, 1'b1, 1'b0);
        check("clear_cnt", int'(uc_cnt), 0);

        // reset colliding with an accept of 3
        cycle(4'b0001, 3, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        cycle(4'b0001, 3, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check("rst_accept_cnt", int'(uc_cnt), 1);

`ifdef UCA_CONFLICT_EN
        // duplicate literal is dropped
        cycle('0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        cycle(4'b0010, 0, 5, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle(4'b0010, 0, 5, 0, 0, 1'b0, 1'b0, 1'b0);
        check("dup_cnt", int'(uc_cnt), 1);
        check("dup_conflict", int'(conflict), 0);

        // opposite polarity halts until clear
        cycle(4'b0001, 9, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle(4'b0100, 0, 0, -9, 0, 1'b0, 1'b0, 1'b0);
        check("cfl_set", int'(conflict), 1);
        repeat (2) cycle(4'hF, 40, 41, 42, 43, 1'b0, 1'b0, 1'b0);
        cycle(4'hF, 40, 41, 42, 43, 1'b0, 1'b1, 1'b0);
        check("cfl_cleared", int'(conflict), 0);
        check("cfl_clear_cnt", int'(uc_cnt), 0);

        // most negative literal maps to index 0
        cycle(4'b0001, -256, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle(4'b0001, -256, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle();
        check("minlit_cnt", int'(uc_cnt), 1);
`else
        // no filtering: repeats and opposite polarity all pushed
        cycle('0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        cycle(4'b0001, 4, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle(4'b0001, 4, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle(4'b0001, -4, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        idle();
        check("nofilt_cnt", int'(uc_cnt), 3);
        check("nofilt_conflict", int'(conflict), 0);
`endif

        // random traffic with occasional full, clear and reset
        for (int n = 0; n < 400; n++) begin
            cycle(NE'($urandom_range(0, 15)),
                  int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                  int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 59) == 0));
        end

`ifndef UCA_CONFLICT_EN
        // counter saturation
        cycle('0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        repeat (1030) cycle(4'hF, 1, -2, 3, -256, 1'b0, 1'b0, 1'b0);
        check("sat_cnt", int'(uc_cnt), CMAX);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
